mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter_rr_pick2.sv | 18 +
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
// Owner encoding is also the encoding of the round-robin "last granted" pointer.
package mem_arbiter_pkg;

  localparam int CORE_AW = 64;
  localparam int CORE_DW = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/grant/response bundle for one memory port; master issues requests,
// slave grants them and returns responses.
interface mem_arbiter_if #(
  parameter int AW = mem_arbiter_pkg::CORE_AW,
  parameter int DW = mem_arbiter_pkg::CORE_DW
) ();

  localparam int SW = DW / 8;

  logic          req;
  logic          wen;
  logic [AW-1:0] addr;
  logic [SW-1:0] strb;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          recv;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (
    output req, wen, addr, strb, wdata,
    input  gnt, recv, err, rdata
  );

  modport slave (
    input  req, wen, addr, strb, wdata,
    output gnt, recv, err, rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the requester that was not granted
// last wins. Bit 0 is imem, bit 1 is dmem; the output is one-hot or zero.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates imem and dmem requesters onto one memory port with zero added
// latency, round-robin fairness and at most one outstanding response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = CORE_AW,
  parameter int DW = CORE_DW
) (
  input  logic          clock,
  input  logic          g_resetn,
  mem_arbiter_if.slave  imem,
  mem_arbiter_if.slave  dmem,
  mem_arbiter_if.master mem
);

  localparam int SW = DW / 8;

  state_e        state_q, state_d;
  owner_e        last_q;
  logic          rsp_pend_q;
  owner_e        rsp_owner_q;

  logic [1:0]    pick;
  owner_e        sel;
  logic          sel_valid;
  logic          sel_req;
  logic          gate;
  logic          fwd_req;
  logic          xfer;
  logic [AW-1:0] addr_sel;
  logic [SW-1:0] strb_sel;
  logic [DW-1:0] wdata_sel;

  rr_pick2 u_pick (
    .req  ({dmem.req, imem.req}),
    .last (last_q),
    .gnt  (pick)
  );

  // Owner is chosen fresh only in IDLE; once locked it holds until granted.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    sel       = OWN_IMEM;
    sel_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_valid = |pick;
        sel       = pick[1] ? OWN_DMEM : OWN_IMEM;
      end
      OWN_I: begin
        sel_valid = 1'b1;
        sel       = OWN_IMEM;
      end
      OWN_D: begin
        sel_valid = 1'b1;
        sel       = OWN_DMEM;
      end
      default: begin
        sel_valid = 1'b0;
        sel       = OWN_IMEM;
      end
    endcase
  end

  assign sel_req   = (sel == OWN_DMEM) ? dmem.req   : imem.req;
  assign addr_sel  = (sel == OWN_DMEM) ? dmem.addr  : imem.addr;
  assign strb_sel  = (sel == OWN_DMEM) ? dmem.strb  : imem.strb;
  assign wdata_sel = (sel == OWN_DMEM) ? dmem.wdata : imem.wdata;

  // A new request may issue when the slot is free or is being freed this cycle.
  // The reset term keeps the request quiet while g_resetn is held low.
  assign gate    = !rsp_pend_q || mem.recv;
  assign fwd_req = g_resetn && sel_valid && sel_req && gate;
  assign xfer    = fwd_req && mem.gnt;

  assign mem.req   = fwd_req;
  assign mem.wen   = (sel == OWN_DMEM) ? dmem.wen : imem.wen;
  assign mem.addr  = addr_sel;
  assign mem.strb  = strb_sel;
  assign mem.wdata = wdata_sel;

  assign imem.gnt = xfer && (sel == OWN_IMEM);
  assign dmem.gnt = xfer && (sel == OWN_DMEM);

  assign imem.recv  = mem.recv && rsp_pend_q && (rsp_owner_q == OWN_IMEM);
  assign dmem.recv  = mem.recv && rsp_pend_q && (rsp_owner_q == OWN_DMEM);
  assign imem.err   = mem.err  && imem.recv;
  assign dmem.err   = mem.err  && dmem.recv;
  assign imem.rdata = mem.rdata;
  assign dmem.rdata = mem.rdata;

  always_comb begin
    state_d = IDLE;
    if (sel_valid && !xfer) begin
      state_d = (sel == OWN_DMEM) ? OWN_D : OWN_I;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= IDLE;
      last_q      <= OWN_IMEM;
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= OWN_IMEM;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        last_q      <= sel;
        rsp_pend_q  <= 1'b1;
        rsp_owner_q <= sel;
      end else if (mem.recv) begin
        rsp_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single transfer, round-robin,
// owner locking, response gating, error routing and mid-transfer reset.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic g_resetn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  mem_arbiter_if #(.AW(64), .DW(64)) imem_if ();
  mem_arbiter_if #(.AW(64), .DW(64)) dmem_if ();
  mem_arbiter_if #(.AW(64), .DW(64)) mem_if ();

  mem_arbiter #(.AW(64), .DW(64)) dut (
    .clock    (clock),
    .g_resetn (g_resetn),
    .imem     (imem_if.slave),
    .dmem     (dmem_if.slave),
    .mem      (mem_if.master)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  initial begin
    imem_if.req = 0; imem_if.wen = 0; imem_if.addr = 0; imem_if.strb = 0; imem_if.wdata = 0;
    dmem_if.req = 0; dmem_if.wen = 0; dmem_if.addr = 0; dmem_if.strb = 0; dmem_if.wdata = 0;
    mem_if.gnt = 0; mem_if.recv = 0; mem_if.err = 0; mem_if.rdata = 0;

    // Reset: requests and memory strobes active, all control outputs quiet
    #2;
    imem_if.req = 1; dmem_if.req = 1; mem_if.gnt = 1; mem_if.recv = 1;
    #1;
    check("rst_mem_req", mem_if.req, 0);
    check("rst_imem_gnt", imem_if.gnt, 0);
    check("rst_dmem_gnt", dmem_if.gnt, 0);
    check("rst_imem_recv", imem_if.recv, 0);
    check("rst_dmem_recv", dmem_if.recv, 0);
    imem_if.req = 0; dmem_if.req = 0; mem_if.gnt = 0; mem_if.recv = 0;
    next(); next();
    g_resetn = 1;

    // Single imem read, granted at once, answered next cycle
    next();
    imem_if.req = 1; imem_if.addr = 64'h1000; mem_if.gnt = 1;
    #1;
    check("a_mem_req", mem_if.req, 1);
    check("a_mem_addr", mem_if.addr, 64'h1000);
    check("a_imem_gnt", imem_if.gnt, 1);
    check("a_dmem_gnt", dmem_if.gnt, 0);
    next();
    imem_if.req = 0; mem_if.gnt = 0; mem_if.recv = 1; mem_if.rdata = 64'hDEAD;
    #1;
    check("a_imem_recv", imem_if.recv, 1);
    check("a_imem_rdata", imem_if.rdata, 64'hDEAD);
    check("a_dmem_recv", dmem_if.recv, 0);
    check("a_mem_req_idle", mem_if.req, 0);
    next();
    mem_if.recv = 0;

    // Fresh reset so the pointer is back to "imem last"
    g_resetn = 0;
    next();
    g_resetn = 1;
    next();
    imem_if.req = 1; imem_if.addr = 64'h1000;
    dmem_if.req = 1; dmem_if.addr = 64'h2000;
    mem_if.gnt = 1;
    #1;
    check("b0_dmem_gnt", dmem_if.gnt, 1);
    check("b0_imem_gnt", imem_if.gnt, 0);
    check("b0_mem_addr", mem_if.addr, 64'h2000);
    next();
    mem_if.recv = 1;
    #1;
    check("b1_imem_gnt", imem_if.gnt, 1);
    check("b1_dmem_gnt", dmem_if.gnt, 0);
    check("b1_dmem_recv", dmem_if.recv, 1);
    check("b1_mem_addr", mem_if.addr, 64'h1000);
    next();
    #1;
    check("b2_dmem_gnt", dmem_if.gnt, 1);
    check("b2_imem_recv", imem_if.recv, 1);
    next();
    #1;
    check("b3_imem_gnt", imem_if.gnt, 1);
    check("b3_dmem_recv", dmem_if.recv, 1);
    next();
    imem_if.req = 0; dmem_if.req = 0; mem_if.gnt = 0;
    #1;
    check("b4_imem_recv", imem_if.recv, 1);
    check("b4_mem_req", mem_if.req, 0);
    next();
    mem_if.recv = 0;

    // Owner locked on imem while grant is withheld and dmem arrives
    next();
    imem_if.req = 1; imem_if.addr = 64'h1000;
    #1;
    check("c0_mem_addr", mem_if.addr, 64'h1000);
    check("c0_imem_gnt", imem_if.gnt, 0);
    next();
    dmem_if.req = 1; dmem_if.addr = 64'h2000; dmem_if.wen = 1; dmem_if.strb = 8'hFF;
    dmem_if.wdata = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("c%0d_mem_addr", i + 1), mem_if.addr, 64'h1000);
      check($sformatf("c%0d_dmem_gnt", i + 1), dmem_if.gnt, 0);
      next();
    end
    mem_if.gnt = 1;
    #1;
    check("c3_imem_gnt", imem_if.gnt, 1);
    check("c3_dmem_gnt", dmem_if.gnt, 0);
    check("c3_mem_addr", mem_if.addr, 64'h1000);

    // Response withheld: no new request may issue
    next();
    imem_if.req = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("d%0d_mem_req", i), mem_if.req, 0);
      check($sformatf("d%0d_dmem_gnt", i), dmem_if.gnt, 0);
      next();
    end
    mem_if.recv = 1; mem_if.rdata = 64'hBEEF;
    #1;
    check("d4_imem_recv", imem_if.recv, 1);
    check("d4_dmem_gnt", dmem_if.gnt, 1);
    check("d4_mem_req", mem_if.req, 1);
    check("d4_mem_wen", mem_if.wen, 1);
    check("d4_mem_strb", mem_if.strb, 64'hFF);
    check("d4_mem_wdata", mem_if.wdata, 64'h0123_4567_89AB_CDEF);

    // Error response lands on dmem, proving the slot reloaded with dmem
    next();
    dmem_if.req = 0; dmem_if.wen = 0; mem_if.gnt = 0; mem_if.err = 1;
    #1;
    check("e_dmem_recv", dmem_if.recv, 1);
    check("e_dmem_err", dmem_if.err, 1);
    check("e_imem_recv", imem_if.recv, 0);
    check("e_imem_err", imem_if.err, 0);
    next();
    mem_if.recv = 0; mem_if.err = 0;

    // Reset between grant and response
    next();
    imem_if.req = 1; mem_if.gnt = 1;
    #1;
    check("f_imem_gnt", imem_if.gnt, 1);
    next();
    imem_if.req = 0; dmem_if.req = 1; mem_if.gnt = 1;
    #2;
    g_resetn = 0;
    mem_if.recv = 1;
    #1;
    check("f_rst_mem_req", mem_if.req, 0);
    check("f_rst_dmem_gnt", dmem_if.gnt, 0);
    check("f_rst_imem_recv", imem_if.recv, 0);
    dmem_if.req = 0; mem_if.gnt = 0;
    next();
    g_resetn = 1;
    next();
    #1;
    check("f_late_imem_recv", imem_if.recv, 0);
    check("f_late_dmem_recv", dmem_if.recv, 0);
    next();
    mem_if.recv = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
